csr_timer_array: RTL and testbench
==================================

// Module: csr_timer_array
// PURPOSE
//  Parametrised bank of N independent LoongArch-style countdown timers (TCFG/TVAL/TICLR per channel)
//  with latched per-channel timer interrupts and 2-flop sampling of external hw interrupt lines.
//  Sits beside the core CSR file, sharing its csr_num/csr_we/csr_wmask/csr_wvalue write port;
//  its csr_rvalue is ORed into the CSR read mux when csr_hit=1. Outputs feed ESTAT.IS[11:2].
// PARAMETERS
//  N_TIMER   2        number of timer channels, 1..8
//  CNT_W     32       counter/TCFG width, 8..32
//  HWI_W     8        external hw interrupt lines sampled
//  CSR_BASE  14'h41   CSR number of channel 0 TCFG; channel i block = CSR_BASE + 4*i
// PORTS
//  clk          in   1          clock; all state on posedge
//  rst_n        in   1          asynchronous reset, active-low
//  csr_num      in   14         CSR address, shared with core CSR file
//  csr_we       in   1          write strobe
//  csr_wmask    in   32         per-bit write mask
//  csr_wvalue   in   32         write data
//  csr_rvalue   out  32         read data for csr_num (combinational); 0 when csr_hit=0
//  csr_hit      out  1          csr_num decodes to a register of this block
//  hw_int_in    in   HWI_W      asynchronous external interrupt lines
//  hw_int_sync  out  HWI_W      hw_int_in after 2-flop synchroniser
//  timer_irq    out  N_TIMER    per-channel latched pending bit
//  timer_irq_any out 1          OR of timer_irq
// BEHAVIOUR
//  - Map per channel i (A=CSR_BASE+4*i): A+0 TCFG, A+1 TVAL (RO), A+2 TDIV (see CONFIGURATION),
//    A+3 TICLR (W1C bit0, reads 0). Upper CNT_W..31 bits read 0, writes ignored.
//  - TCFG = {initval[CNT_W-1:2], periodic[1], en[0]}; write: new = wmask&wvalue | ~wmask&old.
//  - Reset (rst_n=0, async): en=0, periodic=0, initval=0, cnt=all-ones, irq=0, sync flops=0,
//    tdiv=0, prescale counters=0. All outputs 0 except csr_rvalue/csr_hit (pure decode).
//  - step_i = 1 every cycle (no prescaler). Counter next-state, priority high->low:
//    1 TCFG write with new en=1: cnt <= {new initval,2'b00} (also restarts an active count)
//    2 en=1 && step && cnt!=all-ones && cnt==0 && periodic: cnt <= {initval,2'b00}
//    3 en=1 && step && cnt!=all-ones: cnt <= cnt-1 (one-shot 0 -> all-ones, then halts)
//    4 otherwise hold (TCFG write with en=0 freezes cnt; TVAL reads frozen value).
//  - Pending: set when en=1 && step && cnt==0; cleared by TICLR write with wmask[0]&wvalue[0].
//    Same-cycle set and clear: set wins. Pending is not cleared by en=0 or by TCFG writes.
//  - Periodic with initval=0: cnt stays 0, pending reasserts every step.
//  - TVAL read latency 0 (current cnt); write effects visible on the next cycle's read.
//  - hw_int_sync = 2-stage flop of hw_int_in; latency 2 cycles; no edge detect.
//  - csr_hit=1 only for offsets 0,1,3 (and 2 when macro on) of channels 0..N_TIMER-1.
//  - csr_we with csr_hit=0 has no effect. rst_n mid-count aborts immediately to reset state.
// CONFIGURATION
//  CSR_TIMER_PRESCALE_EN defined: A+2 is TDIV (8-bit div[7:0], RW, reset 0). Per-channel
//    prescale counter pc counts 0..div; step=1 when pc==div; pc resets to 0 on TCFG write and
//    when en=0. div=0 gives step every cycle (identical to macro off).
//  Not defined: no TDIV/prescaler; A+2 is not decoded (csr_hit=0, reads 0, writes ignored).
// TESTING
//  T1 reset: release rst_n -> TVAL reads 32'hffffffff, timer_irq=0, hw_int_sync=0, TCFG reads 0.
//  T2 one-shot: TCFG0<=0x11 (initval 4,en) -> TVAL 0x10 next cycle, irq0 set 16 cycles later,
//     TVAL then 0xffffffff and holds; TICLR0 bit0 write -> irq0=0 next cycle.
//  T3 periodic ch1: TCFG1<=0x0B (initval 2) -> TVAL 8,7..0,8,..; irq1 set at each 0; clear on
//     the same cycle as a 0 -> irq1 stays 1; ch0 untouched throughout.
//  T4 masked write: TCFG0=0x11 then write wvalue=0, wmask=0x1 -> en=0, initval kept, TVAL frozen.
//  T5 hw_int_in=8'hA5 asynchronously -> hw_int_sync=8'hA5 after 2 edges; csr_num=CSR_BASE+4*N_TIMER
//     -> csr_hit=0, rvalue 0.
//  T6 (macro on) TDIV0=3, TCFG0<=0x09 (initval 2) -> TVAL decrements every 4 cycles, irq0 at ~36.

Source files
------------

// File: rtl/csr_timer_array.sv
// csr_timer_array: bank of N LoongArch-style countdown timers (TCFG/TVAL/TICLR)
// with latched irqs and a 2-flop hw_int sampler; TDIV prescaler under CSR_TIMER_PRESCALE_EN.
module csr_timer_array #(
  parameter int          N_TIMER  = 2,
  parameter int          CNT_W    = 32,
  parameter int          HWI_W    = 8,
  parameter logic [13:0] CSR_BASE = 14'h41
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [13:0]        csr_num,
  input  logic               csr_we,
  input  logic [31:0]        csr_wmask,
  input  logic [31:0]        csr_wvalue,
  output logic [31:0]        csr_rvalue,
  output logic               csr_hit,
  input  logic [HWI_W-1:0]   hw_int_in,
  output logic [HWI_W-1:0]   hw_int_sync,
  output logic [N_TIMER-1:0] timer_irq,
  output logic               timer_irq_any
);

  localparam logic [CNT_W-1:0] ONES = '1;

  logic [13:0]        off;
  logic [CNT_W-1:0]   wm;
  logic [CNT_W-1:0]   wv;
  logic [N_TIMER-1:0] sel_cfg;
  logic [N_TIMER-1:0] sel_val;
  logic [N_TIMER-1:0] sel_div;
  logic [N_TIMER-1:0] sel_clr;
  logic [31:0]        rd_ch [N_TIMER];
  logic [HWI_W-1:0]   sync_q1;

  // Addresses below CSR_BASE wrap to a huge offset and match no channel.
  assign off = csr_num - CSR_BASE;
  assign wm  = csr_wmask[CNT_W-1:0];
  assign wv  = csr_wvalue[CNT_W-1:0];

  for (genvar i = 0; i < N_TIMER; i++) begin : g_ch
    logic             blk;
    logic [CNT_W-1:0] tcfg;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cfg_new;
    logic             pend;
    logic             en;
    logic             per;
    logic             step;
    logic             wr_cfg;
    logic             clr;
    logic [31:0]      rd;

    assign blk        = (off[13:2] == 12'(i));
    assign sel_cfg[i] = blk && (off[1:0] == 2'd0);
    assign sel_val[i] = blk && (off[1:0] == 2'd1);
    assign sel_clr[i] = blk && (off[1:0] == 2'd3);
    assign en         = tcfg[0];
    assign per        = tcfg[1];
    assign wr_cfg     = csr_we && sel_cfg[i];
    assign clr        = csr_we && sel_clr[i]
                     && csr_wmask[0] && csr_wvalue[0];
    assign cfg_new    = (wm & wv) | (~wm & tcfg);

`ifdef CSR_TIMER_PRESCALE_EN
    logic [7:0] div;
    logic [7:0] pc;

    assign sel_div[i] = blk && (off[1:0] == 2'd2);
    assign step       = (pc == div);

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        div <= '0;
        pc  <= '0;
      end else begin
        if (csr_we && sel_div[i])
          div <= (csr_wmask[7:0] & csr_wvalue[7:0])
               | (~csr_wmask[7:0] & div);
        if (wr_cfg || !en || step)
          pc <= '0;
        else
          pc <= pc + 8'd1;
      end
    end

    always_comb begin
      rd = '0;
      unique case (1'b1)
        sel_cfg[i]: rd = 32'(tcfg);
        sel_val[i]: rd = 32'(cnt);
        sel_div[i]: rd = 32'(div);
        default:    rd = '0;
      endcase
    end
`else
    assign sel_div[i] = 1'b0;
    assign step       = 1'b1;

    always_comb begin
      rd = '0;
      unique case (1'b1)
        sel_cfg[i]: rd = 32'(tcfg);
        sel_val[i]: rd = 32'(cnt);
        default:    rd = '0;
      endcase
    end
`endif

    // Any TCFG write owns cnt this cycle: reload if enabling, else freeze.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        tcfg <= '0;
        cnt  <= ONES;
        pend <= 1'b0;
      end else begin
        if (wr_cfg) begin
          tcfg <= cfg_new;
          if (cfg_new[0])
            cnt <= {cfg_new[CNT_W-1:2], 2'b00};
        end else if (en && step && cnt != ONES) begin
          if (cnt == '0 && per)
            cnt <= {tcfg[CNT_W-1:2], 2'b00};
          else
            cnt <= cnt - CNT_W'(1);
        end
        if (en && step && cnt == '0)
          pend <= 1'b1;
        else if (clr)
          pend <= 1'b0;
      end
    end

    assign rd_ch[i]     = rd;
    assign timer_irq[i] = pend;
  end

  always_comb begin
    csr_rvalue = '0;
    for (int k = 0; k < N_TIMER; k++)
      csr_rvalue = csr_rvalue | rd_ch[k];
  end

  assign csr_hit       = |(sel_cfg | sel_val | sel_div | sel_clr);
  assign timer_irq_any = |timer_irq;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q1     <= '0;
      hw_int_sync <= '0;
    end else begin
      sync_q1     <= hw_int_in;
      hw_int_sync <= sync_q1;
    end
  end

endmodule

// File: tb/tb_csr_timer_array.sv
// tb_csr_timer_array: directed + random stimulus against a cycle-level
// behavioural model of the timer bank, CSR decode and hw_int sampler.
module tb_csr_timer_array;

  localparam int     N    = 2;
  localparam int     CW   = 32;
  localparam int     HW   = 8;
  localparam int     BASE = 'h41;
  localparam longint ONES = (64'd1 << CW) - 1;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [13:0]   csr_num = '0;
  logic          csr_we = 1'b0;
  logic [31:0]   csr_wmask = '0;
  logic [31:0]   csr_wvalue = '0;
  logic [31:0]   csr_rvalue;
  logic          csr_hit;
  logic [HW-1:0] hw_int_in = '0;
  logic [HW-1:0] hw_int_sync;
  logic [N-1:0]  timer_irq;
  logic          timer_irq_any;

  csr_timer_array #(
    .N_TIMER(N), .CNT_W(CW), .HWI_W(HW), .CSR_BASE(14'(BASE))
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .csr_num(csr_num), .csr_we(csr_we),
    .csr_wmask(csr_wmask), .csr_wvalue(csr_wvalue),
    .csr_rvalue(csr_rvalue), .csr_hit(csr_hit),
    .hw_int_in(hw_int_in), .hw_int_sync(hw_int_sync),
    .timer_irq(timer_irq), .timer_irq_any(timer_irq_any)
  );

  always #5 clk = ~clk;

  int n_run = 0;
  int n_fail = 0;

  longint        m_cfg [N];
  longint        m_cnt [N];
  bit            m_irq [N];
  int            m_div [N];
  int            m_pc  [N];
  logic [HW-1:0] m_s1;
  logic [HW-1:0] m_s2;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_run++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic m_reset();
    for (int c = 0; c < N; c++) begin
      m_cfg[c] = 0;
      m_cnt[c] = ONES;
      m_irq[c] = 0;
      m_div[c] = 0;
      m_pc[c]  = 0;
    end
    m_s1 = '0;
    m_s2 = '0;
  endtask

  // {hit, value} for an address, from the register map.
  function automatic logic [32:0] m_read(input int num);
    int o;
    int c;
    if (num < BASE || num >= BASE + 4 * N) return 33'd0;
    o = (num - BASE) % 4;
    c = (num - BASE) / 4;
    case (o)
      0: return {1'b1, 32'(m_cfg[c])};
      1: return {1'b1, 32'(m_cnt[c])};
`ifdef CSR_TIMER_PRESCALE_EN
      2: return {1'b1, 32'(m_div[c])};
`else
      2: return 33'd0;
`endif
      default: return {1'b1, 32'd0};
    endcase
  endfunction

  task automatic m_step(input int num, input bit we,
                        input longint m, input longint v,
                        input logic [HW-1:0] hw);
    for (int c = 0; c < N; c++) begin
      bit     in_blk;
      int     o;
      bit     en;
      bit     per;
      bit     stp;
      bit     fire;
      bit     wc;
      longint ncfg;
      in_blk = we && num >= BASE + 4 * c && num < BASE + 4 * c + 4;
      o    = num - BASE - 4 * c;
      en   = (m_cfg[c] & 1) != 0;
      per  = (m_cfg[c] & 2) != 0;
`ifdef CSR_TIMER_PRESCALE_EN
      stp  = (m_pc[c] == m_div[c]);
`else
      stp  = 1;
`endif
      fire = en && stp && m_cnt[c] == 0;
      wc   = in_blk && o == 0;
      if (wc) begin
        ncfg = ((m & v) | (~m & m_cfg[c])) & ONES;
        if ((ncfg & 1) != 0) m_cnt[c] = (ncfg >> 2) * 4;
        m_cfg[c] = ncfg;
      end else if (en && stp && m_cnt[c] != ONES) begin
        if (m_cnt[c] == 0 && per) m_cnt[c] = (m_cfg[c] >> 2) * 4;
        else m_cnt[c] = (m_cnt[c] - 1) & ONES;
      end
      if (fire) m_irq[c] = 1;
      else if (in_blk && o == 3 && (m & v & 1) != 0) m_irq[c] = 0;
`ifdef CSR_TIMER_PRESCALE_EN
      if (in_blk && o == 2)
        m_div[c] = int'(((m & v) | (~m & m_div[c])) & 255);
      if (wc || !en || stp) m_pc[c] = 0;
      else m_pc[c] = (m_pc[c] + 1) % 256;
`endif
    end
    m_s2 = m_s1;
    m_s1 = hw;
  endtask

  task automatic cycle(input int num, input bit we, input longint m,
                       input longint v, input logic [HW-1:0] hw);
    logic [32:0]  r;
    logic [N-1:0] e;
    @(negedge clk);
    csr_num    = 14'(num);
    csr_we     = we;
    csr_wmask  = 32'(m);
    csr_wvalue = 32'(v);
    hw_int_in  = hw;
    #1;
    r = m_read(num);
    for (int c = 0; c < N; c++) e[c] = m_irq[c];
    chk("rvalue", csr_rvalue, r[31:0]);
    chk("hit", 32'(csr_hit), 32'(r[32]));
    chk("irq", 32'(timer_irq), 32'(e));
    chk("irq_any", 32'(timer_irq_any), 32'(|e));
    chk("sync", 32'(hw_int_sync), 32'(m_s2));
    m_step(num, we, m, v, hw);
  endtask

  task automatic do_reset();
    @(negedge clk);
    csr_we    = 1'b0;
    hw_int_in = '0;
    csr_num   = 14'(BASE + 1);
    #2;
    rst_n = 1'b0;
    #1;
    m_reset();
    chk("rst_irq", 32'(timer_irq), 32'd0);
    chk("rst_sync", 32'(hw_int_sync), 32'd0);
    chk("rst_tval", csr_rvalue, 32'hffffffff);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    longint v;
    longint m;
    m_reset();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // reset state
    cycle(BASE + 1, 0, 0, 0, 0);
    chk("t1_tval", csr_rvalue, 32'hffffffff);
    cycle(BASE, 0, 0, 0, 0);
    chk("t1_tcfg", csr_rvalue, 32'd0);

    // one-shot, initval 4
    cycle(BASE, 1, ONES, 'h11, 0);
    cycle(BASE + 1, 0, 0, 0, 0);
    chk("t2_tval0", csr_rvalue, 32'h10);
    for (int i = 0; i < 20; i++) cycle(BASE + 1, 0, 0, 0, 0);
    chk("t2_irq", 32'(timer_irq), 32'd1);
    chk("t2_tval_end", csr_rvalue, 32'hffffffff);
    cycle(BASE + 3, 1, 1, 1, 0);
    cycle(BASE + 3, 0, 0, 0, 0);
    chk("t2_clr", 32'(timer_irq), 32'd0);
    chk("t2_ticlr_rd", csr_rvalue, 32'd0);

    // periodic ch1, clear coinciding with a zero
    cycle(BASE + 4, 1, ONES, 'h0B, 0);
    for (int i = 0; i < 40; i++) begin
      if (i > 12 && m_cnt[1] == 0) cycle(BASE + 7, 1, 1, 1, 0);
      else cycle(BASE + 5, 0, 0, 0, 0);
    end
    chk("t3_irq1", 32'(timer_irq), 32'd2);

    // masked write disables but keeps initval
    cycle(BASE, 1, ONES, 'h11, 0);
    cycle(BASE + 1, 0, 0, 0, 0);
    cycle(BASE + 1, 0, 0, 0, 0);
    cycle(BASE, 1, 1, 0, 0);
    for (int i = 0; i < 4; i++) cycle(BASE + 1, 0, 0, 0, 0);
    chk("t4_tval", csr_rvalue, 32'h0e);
    cycle(BASE, 0, 0, 0, 0);
    chk("t4_tcfg", csr_rvalue, 32'h10);

    // synchroniser and out-of-range decode
    cycle(BASE, 0, 0, 0, 8'hA5);
    cycle(BASE, 0, 0, 0, 8'hA5);
    cycle(BASE, 0, 0, 0, 8'hA5);
    chk("t5_sync", 32'(hw_int_sync), 32'hA5);
    cycle(BASE + 4 * N, 1, ONES, 'h11, 0);
    chk("t5_hit", 32'(csr_hit), 32'd0);
    chk("t5_rd", csr_rvalue, 32'd0);
    cycle(BASE + 2, 0, 0, 0, 0);

`ifdef CSR_TIMER_PRESCALE_EN
    cycle(BASE + 2, 1, ONES, 3, 0);
    cycle(BASE, 1, ONES, 'h09, 0);
    for (int i = 0; i < 45; i++) cycle(BASE + 1, 0, 0, 0, 0);
`endif

    // abort mid-count
    do_reset();
    cycle(BASE + 5, 0, 0, 0, 0);
    chk("rst_t1", csr_rvalue, 32'hffffffff);

    for (int i = 0; i < 4000; i++) begin
      if (i == 2000) do_reset();
      if ($urandom_range(0, 9) == 0) v = $urandom;
      else v = longint'($urandom_range(0, 9) * 4 + $urandom_range(0, 3));
      if ($urandom_range(0, 9) < 7) m = ONES;
      else m = $urandom;
      cycle(BASE - 2 + $urandom_range(0, 4 * N + 3),
            $urandom_range(0, 9) < 3, m, v, HW'($urandom));
    end

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
